apb_slave: RTL
==============

APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, sets the access-phase wait states inserted before pready (legal 0..15).
REQ-002 Parameter ID_VAL, default 16'hAB01, is the read-only identification value at address 4'hF.
REQ-003 pclk  input  1  is the single clock; all state updates on the rising edge.
REQ-004 preset  input  1  is the reset: synchronous, active-high.
REQ-005 psel  input  1  means the slave is selected by the master.
REQ-006 penable  input  1  marks the APB access phase.
REQ-007 paddr  input  4  is the register address.
REQ-008 pwrite  input  1  means write when 1 and read when 0.
REQ-009 pwdata  input  16  is the write data.
REQ-010 pready  output  1  means the transfer completes this cycle.
REQ-011 prdata  output  16  is the read data, valid only while pready=1 and it is a read.
REQ-012 pslverr  output  1  flags a transfer error, valid only while pready=1.

Function
REQ-013 The storage SHALL be 15 x 16-bit R/W registers at addresses 0..14, plus the read-only ID_VAL at address 15.
REQ-014 The FSM SHALL have states IDLE and ACCESS; encoding 1'b0 and 1'b1.
REQ-015 IDLE -> ACCESS on psel=1 && penable=0 (setup), with these captures:
  - paddr to addr_q; pwrite to wr_q; pwdata to wdata_q.
  - The wait counter is loaded with WAIT_CYCLES.
REQ-016 In IDLE, penable=1 (protocol violation) SHALL be ignored and the FSM remains in IDLE.
REQ-017 In ACCESS with psel=1 && penable=1 && cnt!=0, cnt SHALL decrement by 1 per cycle and pready SHALL be 0.
REQ-018 pready SHALL be combinational: 1 iff state=ACCESS && psel && penable && cnt==0.
REQ-019 Latency: pready rises on access cycle WAIT_CYCLES+1, i.e. WAIT_CYCLES=0 gives a zero-wait transfer.
REQ-020 On the completing edge (pready=1), the FSM SHALL return to IDLE.
  - A back-to-back setup on the following cycle is then accepted with no idle gap.
REQ-021 Write commit: on the completing edge with wr_q=1 and addr_q<15, mem[addr_q] <= wdata_q.
REQ-022 Read: while pready=1 and wr_q=0, prdata SHALL equal mem[addr_q], or ID_VAL when addr_q=15; otherwise prdata = 16'h0000.
REQ-023 pslverr SHALL be 1 iff pready=1 && wr_q=1 && addr_q=15; that write is discarded and storage is unchanged.
REQ-024 psel falling while in ACCESS (abort) SHALL return the FSM to IDLE next edge.
  - No write is committed and pready stays 0.
REQ-025 paddr/pwdata/pwrite changes during ACCESS SHALL be ignored; the captured values govern the transfer.

Reset
REQ-026 With preset=1 at an edge, the following SHALL be forced, overriding any in-flight transfer, which is dropped uncommitted:
  - state=IDLE and cnt=0.
  - addr_q, wr_q and wdata_q = 0.
  - All 15 registers = 16'h0000.
REQ-027 During and after reset, pready=0, prdata=16'h0000 and pslverr=0 until a new transfer completes.

Structure
REQ-028 Shared package apb_pkg SHALL hold:
  - ADDR_W=4 and DATA_W=16.
  - The FSM state constants.
  - ID_ADDR=4'hF.
  These are shared with the existing APB master.
REQ-029 The storage array, write port and read mux SHALL live in sub-module apb_slave_regs; the FSM and counter remain in apb_slave.

Verification
REQ-030 Reset, then read addr 3 -> prdata=16'h0000, pslverr=0; read addr 15 -> prdata=16'hAB01.
REQ-031 WAIT_CYCLES=2: write 16'h1234 to addr 5 -> pready high on the 3rd access cycle; a later read of addr 5 returns 16'h1234.
REQ-032 WAIT_CYCLES=0: back-to-back write addr 1 = 16'h00FF then read addr 1 -> each completes on its first access cycle, and the read returns 16'h00FF.
REQ-033 Write 16'hDEAD to addr 15 -> pslverr=1 with pready; the read of addr 15 still returns 16'hAB01.
REQ-034 Abort case: write addr 7 = 16'h5555 with psel dropped mid-wait -> no pready; a read of addr 7 returns the prior value.
REQ-035 Reset case: preset asserted mid-wait on a write to addr 2 -> the write is lost; reads return 0 afterwards.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: bus widths, FSM state codes and the ID register address shared by the APB slave and master.
package apb_pkg;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 16;
   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_ACCESS = 1'b1;
   localparam logic [ADDR_W-1:0] ID_ADDR = 4'hF;
endpackage

// File: rtl/apb_slave_regs.sv
// apb_slave_regs: 15 x 16-bit R/W register file with a read-only ID word at ID_ADDR.
module apb_slave_regs
   import apb_pkg::*;
#(
   parameter logic [DATA_W-1:0] ID_VAL = 16'hAB01
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [0:14];
   always_ff @(posedge pclk) begin
      if (preset) begin
         for (int i = 0; i < 15; i++) mem[i] <= '0;
      end else if (we && addr != ID_ADDR) begin
         mem[addr] <= wdata;
      end
   end
   assign rdata = (addr == ID_ADDR) ? ID_VAL : mem[addr];
endmodule

// File: rtl/apb_slave.sv
// apb_slave: APB slave FSM with programmable wait states in front of the apb_slave_regs storage.
module apb_slave
   import apb_pkg::*;
#(
   parameter int                WAIT_CYCLES = 2,
   parameter logic [DATA_W-1:0] ID_VAL      = 16'hAB01
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              psel,
   input  logic              penable,
   input  logic [ADDR_W-1:0] paddr,
   input  logic              pwrite,
   input  logic [DATA_W-1:0] pwdata,
   output logic              pready,
   output logic [DATA_W-1:0] prdata,
   output logic              pslverr
);
   logic              state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              wr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata;
   assign pready  = state == ST_ACCESS && psel && penable && cnt == 4'd0;
   assign prdata  = (pready && !wr_q) ? rdata : '0;
   assign pslverr = pready && wr_q && addr_q == ID_ADDR;
   // Dropping psel mid-access is an abort; completion also returns to IDLE so a setup can follow immediately.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
      end else if (state == ST_IDLE) begin
         if (psel && !penable) begin
            state   <= ST_ACCESS;
            cnt     <= 4'(WAIT_CYCLES);
            addr_q  <= paddr;
            wr_q    <= pwrite;
            wdata_q <= pwdata;
         end
      end else if (!psel || pready) begin
         state <= ST_IDLE;
      end else if (penable && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end
   apb_slave_regs #(.ID_VAL(ID_VAL)) u_regs (
      .pclk  (pclk),
      .preset(preset),
      .we    (pready && wr_q),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (rdata)
   );
endmodule
